// File: rtl/decoder_pkg.sv
// Shared opcode constants, FSM state type and index-table hash for the frame decoder.
package decoder_pkg;

  localparam int unsigned FRAME_PIXELS = 307200;
  localparam int unsigned RUN_MAX      = 62;
  localparam int unsigned AddrW        = 19;

  localparam logic [7:0] OP_RGB = 8'hFE;
  localparam logic [7:0] OP_END = 8'hFF;

  // Opcode tag in code[7:6]
  localparam logic [1:0] TAG_INDEX   = 2'b00;
  localparam logic [1:0] TAG_DIFF    = 2'b01;
  localparam logic [1:0] TAG_ILLEGAL = 2'b10;
  localparam logic [1:0] TAG_RUN     = 2'b11;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StOp,
    StLitFetch,
    StLit,
    StRun,
    StDone
  } state_e;

  // (r*3 + g*5 + b*7) mod 64 on an RGB332 pixel
  function automatic logic [5:0] pixel_hash(input logic [7:0] px);
    logic [7:0] sum;
    sum = ({5'd0, px[7:5]} * 8'd3) + ({5'd0, px[4:2]} * 8'd5) + ({6'd0, px[1:0]} * 8'd7);
    return sum[5:0];
  endfunction

endpackage

// File: rtl/decoder_index_table.sv
// 64x8 recently-seen pixel table: one write port, asynchronous read, synchronous clear.
module decoder_index_table (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear_i,
  input  logic       we_i,
  input  logic [5:0] waddr_i,
  input  logic [7:0] wdata_i,
  input  logic [5:0] raddr_i,
  output logic [7:0] rdata_o
);

  logic [7:0] mem_q [64];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 64; i++) mem_q[i] <= '0;
    end else if (clear_i) begin
      for (int i = 0; i < 64; i++) mem_q[i] <= '0;
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/decoder.sv
// Byte-code frame decoder writing RGB332 pixels; the INDEX opcode and its table are built
// only when DECODER_INDEX_EN is defined, otherwise 00xxxxxx is treated as illegal.
module decoder #(
  parameter int unsigned FRAME_PIXELS = decoder_pkg::FRAME_PIXELS,
  parameter int unsigned RUN_MAX      = decoder_pkg::RUN_MAX
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  output logic [18:0] code_addr_o,
  output logic        code_enable_o,
  input  logic [7:0]  code_data_i,
  output logic [18:0] write_addr_o,
  output logic [7:0]  write_data_o,
  output logic        write_enable_o,
  output logic        done_o,
  output logic        error_o
);
  import decoder_pkg::*;

  localparam int unsigned RunW = $clog2(RUN_MAX);

  state_e            state_q, state_d, next_after;
  logic [18:0]       addr_q, addr_d;
  logic [18:0]       count_q, count_d;
  logic [7:0]        prev_q, prev_d;
  logic              err_q, err_d;
  logic [RunW-1:0]   run_q, run_d;
  logic [18:0]       wr_addr_q, wr_addr_d;
  logic [7:0]        wr_data_q, wr_data_d;
  logic              we_q, we_d;
  logic              emit;
  logic              tbl_clear;
  logic [7:0]        pix;
  logic [2:0]        diff_r, diff_g;
  logic [1:0]        diff_b;

  assign diff_r = prev_q[7:5] + {1'b0, code_data_i[5:4]} - 3'd2;
  assign diff_g = prev_q[4:2] + {1'b0, code_data_i[3:2]} - 3'd2;
  assign diff_b = prev_q[1:0] + code_data_i[1:0] - 2'd2;

`ifdef DECODER_INDEX_EN
  logic [7:0] tbl_rdata;

  decoder_index_table u_index_table (
    .clk     (clk),
    .rst     (rst),
    .clear_i (tbl_clear),
    .we_i    (emit),
    .waddr_i (pixel_hash(pix)),
    .wdata_i (pix),
    .raddr_i (code_data_i[5:0]),
    .rdata_o (tbl_rdata)
  );
`endif

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    count_d    = count_q;
    prev_d     = prev_q;
    err_d      = err_q;
    run_d      = run_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    we_d       = 1'b0;
    emit       = 1'b0;
    tbl_clear  = 1'b0;
    pix        = prev_q;
    next_after = StFetch;

    case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d   = StFetch;
          addr_d    = '0;
          count_d   = '0;
          prev_d    = '0;
          err_d     = 1'b0;
          tbl_clear = 1'b1;
        end
      end
      StFetch, StLitFetch: begin
        addr_d  = (addr_q == '1) ? addr_q : addr_q + 19'd1;
        state_d = (state_q == StFetch) ? StOp : StLit;
      end
      StOp: begin
        if (code_data_i == OP_END) begin
          state_d = StDone;
        end else if (code_data_i == OP_RGB) begin
          state_d = StLitFetch;
        end else begin
          unique case (code_data_i[7:6])
            TAG_RUN: begin
              run_d   = RunW'(code_data_i[5:0]);
              state_d = StRun;
            end
            TAG_DIFF: begin
              emit = 1'b1;
              pix  = {diff_r, diff_g, diff_b};
            end
`ifdef DECODER_INDEX_EN
            TAG_INDEX: begin
              emit = 1'b1;
              pix  = tbl_rdata;
            end
            TAG_ILLEGAL: begin
              emit  = 1'b1;
              err_d = 1'b1;
            end
`else
            TAG_INDEX, TAG_ILLEGAL: begin
              emit  = 1'b1;
              err_d = 1'b1;
            end
`endif
          endcase
        end
      end
      StLit: begin
        emit = 1'b1;
        pix  = code_data_i;
      end
      StRun: begin
        emit = 1'b1;
        if (run_q != '0) begin
          run_d      = run_q - 1'b1;
          next_after = StRun;
        end
      end
      StDone: ;
      default: state_d = StIdle;
    endcase

    // The last pixel of the frame ends decoding, truncating any run in progress.
    if (emit) begin
      we_d      = 1'b1;
      wr_addr_d = count_q;
      wr_data_d = pix;
      prev_d    = pix;
      count_d   = count_q + 19'd1;
      state_d   = (count_q == 19'(FRAME_PIXELS - 1)) ? StDone : next_after;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      count_q   <= '0;
      prev_q    <= '0;
      err_q     <= 1'b0;
      run_q     <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      we_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      count_q   <= count_d;
      prev_q    <= prev_d;
      err_q     <= err_d;
      run_q     <= run_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      we_q      <= we_d;
    end
  end

  assign code_addr_o    = addr_q;
  assign code_enable_o  = (state_q == StFetch) || (state_q == StLitFetch);
  assign write_addr_o   = wr_addr_q;
  assign write_data_o   = wr_data_q;
  assign write_enable_o = we_q;
  assign done_o         = (state_q == StDone);
  assign error_o        = err_q;

endmodule

// File: tb/tb_decoder.sv
// Directed bench for decoder: a software decoder model predicts every pixel write and its
// spacing; a per-cycle compare checks the DUT against it, plus literal pins.
module tb_decoder;

  localparam int unsigned FP = 1000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [18:0] code_addr;
  logic        code_enable;
  logic [7:0]  code_data = 8'h00;
  logic [18:0] write_addr;
  logic [7:0]  write_data;
  logic        write_enable;
  logic        done;
  logic        error;

  decoder #(
    .FRAME_PIXELS (FP),
    .RUN_MAX      (62)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start_i        (start),
    .code_addr_o    (code_addr),
    .code_enable_o  (code_enable),
    .code_data_i    (code_data),
    .write_addr_o   (write_addr),
    .write_data_o   (write_data),
    .write_enable_o (write_enable),
    .done_o         (done),
    .error_o        (error)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [2048];

  always @(posedge clk) begin
    if (code_enable) code_data <= mem[code_addr[10:0]];
  end

  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  int         wr_cnt = 0;
  int         last_cyc = 0;
  int         last_addr = 0;
  bit         allow_wr = 1'b0;
  logic [7:0] stream [$];
  logic [7:0] exp_q [$];
  int         exp_gap [$];
  bit         exp_err;
  logic [7:0] got [FP];
  int         m_prev;
  int         m_tbl [64];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: plain software decoder over the code bytes in mem.
  function automatic void m_emit(input int px, input int gap);
    int h;
    exp_q.push_back(8'(px));
    exp_gap.push_back(gap);
    m_prev = px & 255;
    h = (((m_prev >> 5) * 3) + (((m_prev >> 2) & 7) * 5) + ((m_prev & 3) * 7)) % 64;
    m_tbl[h] = m_prev;
  endfunction

  function automatic void model();
    int pc, v, n, r, g, b;
    bit stop;
    exp_q.delete();
    exp_gap.delete();
    exp_err = 1'b0;
    for (int i = 0; i < 64; i++) m_tbl[i] = 0;
    m_prev = 0;
    pc = 0;
    stop = 1'b0;
    while (!stop && exp_q.size() < FP) begin
      v = int'(mem[pc & 2047]);
      pc++;
      if (v == 'hFF) begin
        stop = 1'b1;
      end else if (v == 'hFE) begin
        m_emit(int'(mem[pc & 2047]), 4);
        pc++;
      end else if ((v >> 6) == 3) begin
        n = (v & 63) + 1;
        for (int k = 0; k < n && exp_q.size() < FP; k++) m_emit(m_prev, (k == 0) ? 3 : 1);
      end else if ((v >> 6) == 1) begin
        r = ((m_prev >> 5) + ((v >> 4) & 3) - 2) & 7;
        g = (((m_prev >> 2) & 7) + ((v >> 2) & 3) - 2) & 7;
        b = ((m_prev & 3) + (v & 3) - 2) & 3;
        m_emit((r << 5) | (g << 2) | b, 2);
`ifdef DECODER_INDEX_EN
      end else if ((v >> 6) == 0) begin
        m_emit(m_tbl[v & 63], 2);
`endif
      end else begin
        exp_err = 1'b1;
        m_emit(m_prev, 2);
      end
    end
  endfunction

  // One clock: sample on the falling edge and check any write against the model.
  task automatic cycle();
    @(negedge clk);
    cyc++;
    if (write_enable) begin
      if (!allow_wr || wr_cnt >= exp_q.size()) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write: got addr %0d data %0h expected no write", write_addr,
                 write_data);
      end else begin
        check("wr_addr", 32'(write_addr), 32'(wr_cnt));
        check("wr_data", 32'(write_data), 32'(exp_q[wr_cnt]));
        if (wr_cnt > 0) check("wr_gap", 32'(cyc - last_cyc), 32'(exp_gap[wr_cnt]));
        got[wr_cnt] = write_data;
        last_cyc    = cyc;
        last_addr   = int'(write_addr);
        wr_cnt++;
      end
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_code_addr"}, 32'(code_addr), 32'd0);
    check({tag, "_code_en"}, 32'(code_enable), 32'd0);
    check({tag, "_wr_addr"}, 32'(write_addr), 32'd0);
    check({tag, "_wr_data"}, 32'(write_data), 32'd0);
    check({tag, "_wr_en"}, 32'(write_enable), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_error"}, 32'(error), 32'd0);
  endtask

  task automatic do_reset();
    allow_wr = 1'b0;
    start    = 1'b0;
    rst      = 1'b1;
    #1;
    check_zero("reset");
    cycle();
    cycle();
    rst = 1'b0;
    cycle();
  endtask

  task automatic start_frame();
    for (int i = 0; i < 2048; i++) mem[i] = (i < stream.size()) ? stream[i] : 8'hFF;
    model();
    wr_cnt   = 0;
    last_cyc = 0;
    allow_wr = 1'b1;
    start    = 1'b1;
    cycle();
    start = 1'b0;
  endtask

  task automatic finish_frame(input string tag, input int budget);
    for (int i = 0; i < budget && !done; i++) cycle();
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_writes"}, 32'(wr_cnt), 32'(exp_q.size()));
    check({tag, "_error"}, 32'(error), 32'(exp_err));
    for (int i = 0; i < 5; i++) cycle();
    check({tag, "_done_held"}, 32'(done), 32'd1);
  endtask

  initial begin
    #2;
    do_reset();

    // Single literal then end marker
    stream = {8'hFE, 8'h6D, 8'hFF};
    start_frame();
    finish_frame("lit", 100);
    check("lit_pix0", 32'(got[0]), 32'h6D);
    check("lit_count", 32'(wr_cnt), 32'd1);
    check("lit_err", 32'(error), 32'd0);

    // Deltas: 0x76 encodes r+1/g-1/b+0 on 0x24 -> 0x40; 0x56 on 0x40 -> 0x3C
    do_reset();
    stream = {8'hFE, 8'h24, 8'h76, 8'h56, 8'hFF};
    start_frame();
    finish_frame("diff", 100);
    check("diff_pix1", 32'(got[1]), 32'h40);
    check("diff_pix2", 32'(got[2]), 32'h3C);

    // Literal then run of 4 on consecutive cycles
    do_reset();
    stream = {8'hFE, 8'h80, 8'hC3, 8'hFF};
    start_frame();
    finish_frame("run", 100);
    check("run_count", 32'(wr_cnt), 32'd5);
    check("run_pix4", 32'(got[4]), 32'h80);
    check("run_last_addr", 32'(last_addr), 32'd4);

    // Index lookup of hash(E3)=0x2A, then a delta; error is sticky when INDEX is illegal
    do_reset();
    stream = {8'hFE, 8'hE3, 8'hFE, 8'h00, 8'h2A, 8'h56, 8'hFF};
    start_frame();
    finish_frame("index", 100);
`ifdef DECODER_INDEX_EN
    check("index_pix2", 32'(got[2]), 32'hE3);
    check("index_pix3", 32'(got[3]), 32'hDF);
    check("index_err", 32'(error), 32'd0);
`else
    check("index_pix2", 32'(got[2]), 32'h00);
    check("index_pix3", 32'(got[3]), 32'hFC);
    check("index_err", 32'(error), 32'd1);
`endif

    // Illegal 10xxxxxx repeats prev and sets error, decoding continues
    do_reset();
    stream = {8'hFE, 8'h12, 8'h85, 8'hC1, 8'hFF};
    start_frame();
    finish_frame("illegal", 100);
    check("illegal_pix1", 32'(got[1]), 32'h12);
    check("illegal_count", 32'(wr_cnt), 32'd4);
    check("illegal_err", 32'(error), 32'd1);

    // Frame fill: 1 + 17*62 pixels exceed FP, last run truncated
    do_reset();
    stream = {8'hFE, 8'h00};
    for (int i = 0; i < 17; i++) stream.push_back(8'hFD);
    start_frame();
    finish_frame("frame", 3000);
    check("frame_count", 32'(wr_cnt), 32'(FP));
    check("frame_last_addr", 32'(last_addr), 32'(FP - 1));

    // Reset after the 10th write abandons the frame
    do_reset();
    start_frame();
    for (int i = 0; i < 200 && wr_cnt < 10; i++) cycle();
    check("midrst_writes", 32'(wr_cnt), 32'd10);
    allow_wr = 1'b0;
    rst      = 1'b1;
    #1;
    check_zero("midrst");
    cycle();
    cycle();
    rst = 1'b0;
    for (int i = 0; i < 20; i++) cycle();
    check("midrst_idle_done", 32'(done), 32'd0);
    check("midrst_idle_code_en", 32'(code_enable), 32'd0);
    check("midrst_idle_wr_en", 32'(write_enable), 32'd0);
    stream = {8'hFE, 8'h6D, 8'hFF};
    start_frame();
    finish_frame("restart", 100);
    check("restart_pix0", 32'(got[0]), 32'h6D);
    check("restart_addr", 32'(last_addr), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
